axi_master_arbiter: RTL and testbench

Shares the single `Axi4_Lite_Master` command port between `NUM_REQ` requesters, such as the UART frame parser and a status poller. It serialises single-beat 32-bit register accesses with round-robin fairness and drives the master's `cmd`/`addr`/`write_data`/`start_transaction` inputs. It returns per-requester responses built from `axi_status` and `read_data`. It sits between the bridge-side requesters and `Axi4_Lite_Master`, which in turn drives `Register_Block`.

---
 rtl/axi_arb_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/axi_master_arbiter.sv | 106 ++++++++++
 tb/tb_axi_master_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state, status and command-field definitions for the master arbiter
package axi_arb_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN, REJECT} arb_state_t;
  localparam logic [7:0] ARB_ST_OK = 8'h00;
  localparam logic [7:0] ARB_ST_BAD_LEN = 8'hF0;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_SIZE_MSB = 5;
  localparam int CMD_SIZE_LSB = 4;
  localparam int CMD_LEN_MSB = 3;
  localparam int CMD_LEN_LSB = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker searching upward from last+1 with wrap
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);
  logic [W-1:0] idx;
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx = '0;
    // walk farthest-first so the closest candidate after last is written last and wins
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: serialises single-beat register accesses from several requesters
// onto one AXI4-Lite master command port with round-robin fairness.
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_cmd,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_status,
  output logic [31:0]            rsp_rdata,
  output logic                   busy,
  output logic [7:0]             m_cmd,
  output logic [31:0]            m_addr,
  output logic [7:0]             m_write_data [64],
  output logic                   m_start_transaction,
  input  logic                   m_transaction_done,
  input  logic [7:0]             m_axi_status,
  input  logic [7:0]             m_read_data [64],
  input  logic [5:0]             m_read_data_count
);
  localparam int W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t state, nxt;
  logic [W-1:0] last_grant, win, gnt_idx;
  logic gnt_any, unused_rd;
  logic [7:0] cmd_q, sel_cmd;
  logic [31:0] addr_q, wdata_q, sel_addr, sel_wdata, rd_masked;
  logic [NUM_REQ-1:0] win_oh;
  rr_arbiter #(.N(NUM_REQ), .W(W)) u_rr (
    .req(req_valid),
    .last(last_grant),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );
  always_comb begin
    sel_cmd = req_cmd[8*int'(gnt_idx) +: 8];
    sel_addr = req_addr[32*int'(gnt_idx) +: 32];
    sel_wdata = req_wdata[32*int'(gnt_idx) +: 32];
    rd_masked = '0;
    for (int i = 0; i < 4; i++) rd_masked[8*i +: 8] = (6'(i) < m_read_data_count) ? m_read_data[i] : 8'h00;
    unused_rd = 1'b0;
    for (int i = 4; i < 64; i++) unused_rd = unused_rd ^ (^m_read_data[i]);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !gnt_any ? IDLE : (sel_cmd[CMD_LEN_MSB:CMD_LEN_LSB] != '0 ? REJECT : START);
      START:   nxt = WAIT;
      WAIT:    nxt = m_transaction_done ? RESP : WAIT;
      RESP:    nxt = DRAIN;
      DRAIN:   nxt = m_transaction_done ? DRAIN : IDLE;
      REJECT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= W'(NUM_REQ - 1);
      win <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_status <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && gnt_any) begin
        win <= gnt_idx;
        last_grant <= gnt_idx;
        cmd_q <= sel_cmd;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
        // rejected requests answer in the very next cycle, so their response is staged now
        if (sel_cmd[CMD_LEN_MSB:CMD_LEN_LSB] != '0) begin
          rsp_status <= ARB_ST_BAD_LEN;
          rsp_rdata <= '0;
        end
      end
      if (state == WAIT && m_transaction_done) begin
        rsp_status <= m_axi_status;
        rsp_rdata <= rd_masked;
      end
    end
  end
  assign win_oh = NUM_REQ'(1) << win;
  assign req_ready = (state == START || state == REJECT) ? win_oh : '0;
  assign rsp_valid = (state == RESP || state == REJECT) ? win_oh : '0;
  assign m_start_transaction = state == START;
  assign busy = state != IDLE;
  assign m_cmd = cmd_q;
  assign m_addr = addr_q;
  for (genvar g = 0; g < 64; g++) begin : g_wd
    if (g < 4) begin : g_byte
      assign m_write_data[g] = wdata_q[8*g +: 8];
    end else begin : g_zero
      assign m_write_data[g] = 8'h00;
    end
  end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb_axi_master_arbiter: directed bench with a register-file master model behind the arbiter
module tb_axi_master_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req_valid = '0;
  logic [15:0] req_cmd = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_status, m_cmd, m_axi_status;
  logic [31:0] rsp_rdata, m_addr;
  logic busy, m_start_transaction, m_transaction_done;
  logic [7:0] m_write_data [64];
  logic [7:0] m_read_data [64];
  logic [5:0] m_read_data_count;
  axi_master_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_rdata(rsp_rdata), .busy(busy), .m_cmd(m_cmd), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_start_transaction(m_start_transaction), .m_transaction_done(m_transaction_done),
    .m_axi_status(m_axi_status), .m_read_data(m_read_data), .m_read_data_count(m_read_data_count)
  );
  int dcnt = 0, hcnt = 0, hold_len = 1;
  logic ovr = 1'b0;
  logic [31:0] ovr_word = '0, rd_word;
  logic [5:0] ovr_cnt = '0;
  logic [7:0] st_val = '0;
  logic [31:0] regs [16] = '{default: 32'h0};
  // master model: done rises two cycles after the start pulse and stays high hold_len cycles
  always @(posedge clk) begin
    if (rst) begin
      dcnt <= 0;
      hcnt <= 0;
    end else begin
      if (m_start_transaction) begin
        dcnt <= 2;
        if (!m_cmd[7]) regs[m_addr[5:2]] <= {m_write_data[3], m_write_data[2], m_write_data[1], m_write_data[0]};
      end else if (dcnt != 0) dcnt <= dcnt - 1;
      if (dcnt == 1) hcnt <= hold_len;
      else if (hcnt != 0) hcnt <= hcnt - 1;
    end
  end
  assign m_transaction_done = hcnt != 0;
  assign m_axi_status = st_val;
  assign rd_word = ovr ? ovr_word : regs[m_addr[5:2]];
  assign m_read_data_count = ovr ? ovr_cnt : (m_cmd[7] ? 6'd4 : 6'd0);
  always_comb begin
    for (int i = 0; i < 64; i++) m_read_data[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_read_data[i] = rd_word[8*i +: 8];
  end
  int starts = 0, both_n = 0, bad_grant = 0;
  int rsp_n [2] = '{0, 0};
  logic [7:0] rsp_st [2];
  logic [31:0] rsp_rd [2];
  int gq [$];
  always @(negedge clk) begin
    if (m_start_transaction) starts++;
    if (req_ready != 2'b00 && m_transaction_done) bad_grant++;
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i]) gq.push_back(i);
      if (rsp_valid[i]) begin
        rsp_n[i]++;
        rsp_st[i] = rsp_status;
        rsp_rd[i] = rsp_rdata;
      end
      if (req_ready[i] && rsp_valid[i]) both_n++;
    end
  end
  int n_chk = 0, n_err = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ready;
    end
  endtask
  task automatic post(int i, logic [7:0] c, logic [31:0] a, logic [31:0] d);
    req_cmd[8*i +: 8] = c;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
    req_valid[i] = 1'b1;
  endtask
  task automatic settle(int budget);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while ((busy || req_valid != 2'b00) && n < budget);
    check("settle_idle", {30'd0, busy, |req_valid}, 32'd0);
  endtask
  int s0, b0, n0, n1;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_start", m_start_transaction, 0);
    check("rst_m_cmd", m_cmd, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_wd0", m_write_data[0], 0);
    check("rst_status", rsp_status, 0);
    check("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    cyc(1);
    // write then read back through the model register file
    post(0, 8'h20, 32'h1020, 32'hA5A5A5A5);
    cyc(1);
    check("wr_ready", req_ready, 2'b01);
    check("wr_start", m_start_transaction, 1);
    check("wr_m_addr", m_addr, 32'h1020);
    check("wr_m_cmd", m_cmd, 8'h20);
    check("wr_wd0", m_write_data[0], 8'hA5);
    check("wr_wd4", m_write_data[4], 8'h00);
    cyc(1);
    check("wait_busy_nostart", {busy, m_start_transaction}, 2'b10);
    check("wait_hold_addr", m_addr, 32'h1020);
    settle(50);
    check("wr_rsp_n", rsp_n[0], 1);
    check("wr_status", rsp_st[0], 8'h00);
    post(0, 8'hA0, 32'h1020, 32'h0);
    settle(50);
    check("rd_rsp_n", rsp_n[0], 2);
    check("rd_status", rsp_st[0], 8'h00);
    check("rd_data", rsp_rd[0], 32'hA5A5A5A5);
    check("rd_hold", rsp_rdata, 32'hA5A5A5A5);
    check("wr_rd_starts", starts, 2);
    // round robin: fresh reset so requester 0 wins first contention
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    gq.delete();
    s0 = starts;
    post(0, 8'h20, 32'h1020, 32'h1);
    post(1, 8'hA0, 32'h1020, 32'h0);
    settle(100);
    check("rr1_rd", rsp_rd[1], 32'h1);
    post(0, 8'h20, 32'h1024, 32'h55);
    settle(50);
    post(0, 8'h20, 32'h1020, 32'h2);
    post(1, 8'hA0, 32'h1020, 32'h0);
    settle(100);
    check("rr2_rd", rsp_rd[1], 32'h1);
    check("rr_n", gq.size(), 5);
    if (gq.size() == 5) begin
      check("rr_g0", gq[0], 0);
      check("rr_g1", gq[1], 1);
      check("rr_g3", gq[3], 1);
      check("rr_g4", gq[4], 0);
    end
    check("rr_starts", starts - s0, 5);
    // bad length rejected without starting the master
    s0 = starts;
    b0 = both_n;
    post(1, 8'h21, 32'h1020, 32'h0);
    cyc(1);
    check("rej_ready_rsp", {req_ready, rsp_valid}, 4'b1010);
    check("rej_status", rsp_status, 8'hF0);
    check("rej_rdata", rsp_rdata, 32'h0);
    settle(10);
    check("rej_starts", starts - s0, 0);
    check("rej_both", both_n - b0, 1);
    // partial read count masks upper bytes
    ovr = 1'b1;
    ovr_word = 32'h44332211;
    ovr_cnt = 6'd2;
    post(0, 8'hA0, 32'h1020, 32'h0);
    settle(50);
    check("part_rdata", rsp_rd[0], 32'h00002211);
    ovr = 1'b0;
    // done held for 5 cycles
    hold_len = 5;
    st_val = 8'h02;
    gq.delete();
    b0 = bad_grant;
    n0 = rsp_n[0];
    n1 = rsp_n[1];
    post(0, 8'h20, 32'h1024, 32'h0BADF00D);
    post(1, 8'hA0, 32'h1020, 32'h0);
    settle(100);
    check("hold_bad_grant", bad_grant - b0, 0);
    check("hold_rsp0", rsp_n[0] - n0, 1);
    check("hold_rsp1", rsp_n[1] - n1, 1);
    check("hold_grants", gq.size(), 2);
    check("hold_rd1", rsp_rd[1], 32'h2);
    check("hold_st0", rsp_st[0], 8'h02);
    hold_len = 1;
    st_val = 8'h00;
    // reset during WAIT
    post(0, 8'h20, 32'h1028, 32'h12345678);
    cyc(2);
    check("abort_wd0", m_write_data[0], 8'h78);
    check("abort_wd3", m_write_data[3], 8'h12);
    check("abort_busy", busy, 1);
    n0 = rsp_n[0];
    rst = 1'b1;
    cyc(1);
    check("abort_busy0", busy, 0);
    check("abort_m_cmd", m_cmd, 0);
    check("abort_m_addr", m_addr, 0);
    check("abort_status", rsp_status, 0);
    check("abort_start", m_start_transaction, 0);
    check("abort_ready", {req_ready, rsp_valid}, 0);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    check("abort_no_rsp", rsp_n[0] - n0, 0);
    post(0, 8'hA0, 32'h1020, 32'h0);
    settle(50);
    check("fresh_rsp", rsp_n[0] - n0, 1);
    check("fresh_rd", rsp_rd[0], 32'h2);
    check("fresh_status", rsp_st[0], 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
